// File: rtl/idata_capture_ctrl.sv
// rtl/idata_capture_ctrl.sv - Sampled parallel-input capture FIFO with Avalon-MM register access
//
// Samples in_port into a small FIFO on a strobe rising edge (mode 0) or on a
// programmable periodic tick (mode 1). Software drains the FIFO through the
// DATA register and watches fill level and overflow through STATUS.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    synchronous active-low reset
//   address    register word address (0 DATA, 1 STATUS, 2 CONTROL, 3 PERIOD)
//   read       read strobe; readdata is valid one cycle later
//   write      write strobe
//   writedata  write data
//   readdata   registered read data
//   in_port    parallel word to sample
//   in_strobe  capture request, synchronous to clk
//   irq        level interrupt: irq_en & (fifo not empty | overflow)

module idata_capture_ctrl #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_strobe,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              enable;
    logic              mode;
    logic              irq_en;
    logic [15:0]       period;
    logic [15:0]       tick_cnt;
    logic              strobe_q;
    logic              overflow;

    logic              fifo_empty;
    logic              fifo_full;
    logic              flush;
    logic              pop;
    logic              tick_hit;
    logic              cap_event;
    logic              push_req;
    logic              push;
    logic              ovf_set;
    logic              ovf_clr;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);
        flush      = write && (address == ADDR_CTRL) && writedata[3];
        pop        = read && (address == ADDR_DATA) && !fifo_empty;
        tick_hit   = (tick_cnt == period);
        cap_event  = enable && (mode ? tick_hit : (in_strobe && !strobe_q));
        // A flush in the same cycle discards the capture outright.
        push_req   = cap_event && !flush;
        // When full, a coincident pop frees the slot the push refills.
        push       = push_req && (!fifo_full || pop);
        ovf_set    = push_req && fifo_full && !pop;
        ovf_clr    = write && (address == ADDR_STATUS) && writedata[10];

        status_word        = '0;
        status_word[4:0]   = 5'(count);
        status_word[8]     = fifo_full;
        status_word[9]     = fifo_empty;
        status_word[10]    = overflow;

        rd_mux = '0;
        case (address)
            ADDR_DATA:   rd_mux = fifo_empty ? 32'd0 : 32'(mem[rd_ptr]);
            ADDR_STATUS: rd_mux = status_word;
            ADDR_CTRL:   rd_mux = {29'd0, irq_en, mode, enable};
            ADDR_PERIOD: rd_mux = {16'd0, period};
            default:     rd_mux = '0;
        endcase
    end

    // Storage array needs no reset: count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_port;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable <= 1'b0;
            mode   <= 1'b0;
            irq_en <= 1'b0;
            period <= '0;
        end else if (write) begin
            if (address == ADDR_CTRL) begin
                enable <= writedata[0];
                mode   <= writedata[1];
                irq_en <= writedata[2];
            end
            if (address == ADDR_PERIOD) begin
                period <= writedata[15:0];
            end
        end
    end

    // Counter is not cleared by a PERIOD change; if it is already past the
    // new value it runs on through 0xFFFF and wraps before matching.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            tick_cnt <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= in_strobe;
            tick_cnt <= tick_hit ? 16'd0 : tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            irq <= irq_en && (!fifo_empty || overflow);
            if (read) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_idata_capture_ctrl.sv
// tb/tb_idata_capture_ctrl.sv - Scoreboard testbench for idata_capture_ctrl

module tb_idata_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [23:0] in_port;
    logic        in_strobe;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_valid = 1'b0;

    localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_PER = 2'd3;

    idata_capture_ctrl #(.DATA_W(24), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .in_strobe (in_strobe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_valid <= read & reset_n;

    // Monitor: every completed read is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: readdata=%08h with no expectation queued", readdata);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (readdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: readdata=%08h expected=%08h", nm, readdata, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // One bus/stimulus cycle; called and returning just after a falling edge.
    task automatic step(input logic [1:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic stb, input logic [23:0] pv,
                        input logic [31:0] exp, input string nm);
        address   = a;
        read      = rd;
        write     = wr;
        writedata = wd;
        in_strobe = stb;
        in_port   = pv;
        if (rd) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
        @(negedge clk);
        read      = 1'b0;
        write     = 1'b0;
        in_strobe = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(a, 1'b0, 1'b1, d, 1'b0, in_port, 32'd0, "");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        step(a, 1'b1, 1'b0, 32'd0, 1'b0, in_port, e, nm);
    endtask

    task automatic strobe(input logic [23:0] v);
        step(A_DATA, 1'b0, 1'b0, 32'd0, 1'b1, v, 32'd0, "");
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; address = '0; read = 0; write = 0; writedata = '0;
        in_port = '0; in_strobe = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(A_STAT, 32'h200, "rst_status");
        rd(A_CTRL, 32'h0, "rst_ctrl");
        rd(A_PER, 32'h0, "rst_period");

        // Strobe mode basic capture and drain
        wr(A_CTRL, 32'h1);
        strobe(24'h123456);
        strobe(24'hABCDEF);
        rd(A_STAT, 32'h002, "m0_count2");
        idle(2);
        check("readdata_hold", readdata, 32'h002);
        rd(A_DATA, 32'h00123456, "m0_data0");
        rd(A_DATA, 32'h00ABCDEF, "m0_data1");
        rd(A_DATA, 32'h0, "m0_data_empty");
        rd(A_STAT, 32'h200, "m0_empty");

        // Periodic mode, PERIOD=3
        wr(A_CTRL, 32'h0);
        wr(A_PER, 32'hABCD1234);
        rd(A_PER, 32'h1234, "period_mask");
        wr(A_PER, 32'h3);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 16; k++) begin
            in_port = 24'(k);
            @(negedge clk);
        end
        in_port = 24'd17;
        wr(A_CTRL, 32'h0);
        rd(A_STAT, 32'h104, "p3_full");
        rd(A_DATA, 32'd4, "p3_cap0");
        rd(A_DATA, 32'd8, "p3_cap1");
        rd(A_DATA, 32'd12, "p3_cap2");
        rd(A_DATA, 32'd16, "p3_cap3");
        rd(A_STAT, 32'h200, "p3_drained");

        // Periodic mode, PERIOD=0: every cycle, overflow on the 5th
        wr(A_PER, 32'h0);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 5; k++) begin
            in_port = 24'(k);
            @(negedge clk);
        end
        wr(A_CTRL, 32'h0);
        rd(A_STAT, 32'h504, "p0_overflow");
        rd(A_DATA, 32'd1, "p0_cap0");
        rd(A_DATA, 32'd2, "p0_cap1");
        rd(A_DATA, 32'd3, "p0_cap2");
        rd(A_DATA, 32'd4, "p0_cap3");
        rd(A_STAT, 32'h600, "p0_ovf_empty");

        // irq from overflow alone, W1C clear
        check("irq_disabled", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h4);
        idle(1);
        check("irq_ovf", {31'd0, irq}, 32'd1);
        wr(A_STAT, 32'h400);
        check("irq_latency", {31'd0, irq}, 32'd1);
        idle(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd(A_STAT, 32'h200, "w1c_status");

        // Overflow set wins over coincident W1C
        wr(A_CTRL, 32'h5);
        strobe(24'h11);
        strobe(24'h22);
        strobe(24'h33);
        strobe(24'h44);
        step(A_STAT, 1'b0, 1'b1, 32'h400, 1'b1, 24'h99, 32'd0, "");
        idle(1);
        rd(A_STAT, 32'h504, "set_wins");
        wr(A_STAT, 32'h400);
        rd(A_STAT, 32'h104, "full_ovf_clr");

        // Full FIFO: pop coincident with capture
        step(A_DATA, 1'b1, 1'b0, 32'd0, 1'b1, 24'h55, 32'h11, "full_pop_head");
        idle(1);
        rd(A_STAT, 32'h104, "full_pushpop_status");
        rd(A_DATA, 32'h22, "full_pp_d1");
        rd(A_DATA, 32'h33, "full_pp_d2");
        rd(A_DATA, 32'h44, "full_pp_d3");
        rd(A_DATA, 32'h55, "full_pp_newest");
        rd(A_STAT, 32'h200, "full_pp_drained");

        // Flush with coincident capture
        wr(A_CTRL, 32'h1);
        strobe(24'h1);
        strobe(24'h2);
        strobe(24'h3);
        rd(A_STAT, 32'h003, "pre_flush_count");
        step(A_CTRL, 1'b0, 1'b1, 32'h9, 1'b1, 24'h77, 32'd0, "");
        idle(1);
        rd(A_STAT, 32'h200, "flush_status");
        rd(A_DATA, 32'h0, "flush_data");
        rd(A_CTRL, 32'h1, "flush_selfclear");

        // Reset mid-operation
        wr(A_PER, 32'h7);
        wr(A_CTRL, 32'h5);
        strobe(24'hA);
        strobe(24'hB);
        idle(1);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rd(A_STAT, 32'h002, "pre_rst_status");
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_readdata", readdata, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rd(A_STAT, 32'h200, "mid_rst_status");
        rd(A_CTRL, 32'h0, "mid_rst_ctrl");
        rd(A_PER, 32'h0, "mid_rst_period");
        strobe(24'hC);
        rd(A_STAT, 32'h200, "post_rst_ignored");
        wr(A_CTRL, 32'h1);
        strobe(24'hD);
        rd(A_STAT, 32'h001, "post_rst_enabled");
        rd(A_DATA, 32'hD, "post_rst_data");

        idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
